// File: rtl/alu_issue_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_pkg
// Shared defaults and record types for the ALU issue front-end.
//   DEFAULT_WIDTH / DEFAULT_OP_W / DEFAULT_TAG_W / DEFAULT_FIFO_DEPTH
//                 default parameter values for alu_issue_ctrl
//   rsp_t         one returned result: {tag, data}
//   cmd_t         one command as offered on the command stream
// ---------------------------------------------------------------------------
package alu_issue_pkg;

    localparam int DEFAULT_WIDTH      = 16;
    localparam int DEFAULT_OP_W       = 4;
    localparam int DEFAULT_TAG_W      = 4;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [DEFAULT_TAG_W-1:0] tag;
        logic [DEFAULT_WIDTH-1:0] data;
    } rsp_t;

    typedef struct packed {
        logic [DEFAULT_OP_W-1:0]  op;
        logic [DEFAULT_WIDTH-1:0] a;
        logic [DEFAULT_WIDTH-1:0] b;
        logic [DEFAULT_TAG_W-1:0] tag;
        logic                     chain;
    } cmd_t;

endpackage

// File: rtl/alu_issue_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// alu_rsp_fifo
// Small synchronous FIFO holding tagged results until the consumer takes them.
// The head entry is always visible on o_head; it only moves on a pop.
//   clk, rst   clock and asynchronous active-high reset
//   i_push     write i_data this edge (ignored when full and not popping)
//   i_pop      drop the head entry this edge (ignored when empty)
//   i_data     entry to write
//   o_head     entry at the read pointer
//   o_count    number of stored entries, 0..DEPTH
//   o_empty    no entries stored
// ---------------------------------------------------------------------------
module alu_rsp_fifo
    import alu_issue_pkg::*;
#(
    parameter int  DEPTH = DEFAULT_FIFO_DEPTH,
    parameter type T     = rsp_t,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  T                 i_data,
    output T                 o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty
);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_doPush;
    logic             w_doPop;

    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_head   = r_mem[r_rdPtr];

    // A pop frees a slot in the same edge, so a push into a full FIFO is
    // still allowed when it coincides with a pop.
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!w_full || w_doPop);

    // Storage and pointers. Memory is cleared on reset so the head reads as
    // zero out of reset. DEPTH is a power of two, so the pointers wrap on
    // their own natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= i_data;
                r_wrPtr        <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
        end
    end

    // Occupancy: simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Command front-end for the combinational ALU. Accepted commands sit in the
// issue register for one cycle while the ALU computes; the result is then
// captured, tagged, and queued for the response stream. An accumulator keeps
// the last result so a command can chain on it.
//   clk, rst                clock and asynchronous active-high reset
//   i_cmd_valid/o_cmd_ready command handshake
//   i_cmd_op/a/b/tag/chain  command fields (a ignored when chain=1)
//   o_alu_a/o_alu_b/o_alu_op  ALU operand and op drive
//   i_alu_result            combinational ALU output
//   o_rsp_valid/i_rsp_ready response handshake
//   o_rsp_data/o_rsp_tag    response fields
//   o_busy                  issue register or result FIFO occupied
// ---------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int OP_W       = DEFAULT_OP_W,
    parameter int TAG_W      = DEFAULT_TAG_W,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [OP_W-1:0]  i_cmd_op,
    input  logic [WIDTH-1:0] i_cmd_a,
    input  logic [WIDTH-1:0] i_cmd_b,
    input  logic [TAG_W-1:0] i_cmd_tag,
    input  logic             i_cmd_chain,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [OP_W-1:0]  o_alu_op,
    input  logic [WIDTH-1:0] i_alu_result,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_data,
    output logic [TAG_W-1:0] o_rsp_tag,
    output logic             o_busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] data;
    } rspEntry_t;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
    } issueEntry_t;

    logic             r_issueValid;
    issueEntry_t      r_issue;
    logic [WIDTH-1:0] r_acc;
    logic             w_accept;
    logic [WIDTH-1:0] w_operandA;
    logic             w_pop;
    rspEntry_t        w_pushEntry;
    rspEntry_t        w_head;
    logic [CNT_W-1:0] w_fifoCount;
    logic             w_fifoEmpty;

    // Credit check counts the in-flight command against the FIFO so its
    // result always has a slot. Depends only on registered state.
    assign o_cmd_ready = ({1'b0, w_fifoCount} + (CNT_W+1)'(r_issueValid))
                         < (CNT_W+1)'(FIFO_DEPTH);
    assign w_accept    = i_cmd_valid && o_cmd_ready;

    // Chaining onto a command still in the issue register takes its result
    // straight off the ALU, which is what the accumulator would hold next.
    always_comb begin
        w_operandA = i_cmd_a;
        if (i_cmd_chain) begin
            w_operandA = r_issueValid ? i_alu_result : r_acc;
        end
    end

    // Issue register: valid for exactly one cycle per accepted command.
    // Fields keep their last values when idle so the ALU inputs hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issueValid <= 1'b0;
            r_issue      <= '0;
        end else begin
            r_issueValid <= w_accept;
            if (w_accept) begin
                r_issue.op  <= i_cmd_op;
                r_issue.a   <= w_operandA;
                r_issue.b   <= i_cmd_b;
                r_issue.tag <= i_cmd_tag;
            end
        end
    end

    // Accumulator follows every executed result and holds while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (r_issueValid) begin
            r_acc <= i_alu_result;
        end
    end

    assign o_alu_a  = r_issue.a;
    assign o_alu_b  = r_issue.b;
    assign o_alu_op = r_issue.op;

    assign w_pushEntry.tag  = r_issue.tag;
    assign w_pushEntry.data = i_alu_result;
    assign w_pop            = o_rsp_valid && i_rsp_ready;

    alu_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (rspEntry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_issueValid),
        .i_pop   (w_pop),
        .i_data  (w_pushEntry),
        .o_head  (w_head),
        .o_count (w_fifoCount),
        .o_empty (w_fifoEmpty)
    );

    assign o_rsp_valid = !w_fifoEmpty;
    assign o_rsp_data  = w_head.data;
    assign o_rsp_tag   = w_head.tag;
    assign o_busy      = r_issueValid || !w_fifoEmpty;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Directed bench for alu_issue_ctrl with an adder standing in for the ALU.
// Expected responses are queued when a command is accepted; a monitor pops
// and compares them whenever a response is handed over.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;
    import alu_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmdValid;
    logic        cmdReady;
    logic [3:0]  cmdOp;
    logic [15:0] cmdA;
    logic [15:0] cmdB;
    logic [3:0]  cmdTag;
    logic        cmdChain;
    logic [15:0] aluA;
    logic [15:0] aluB;
    logic [3:0]  aluOp;
    logic [15:0] aluResult;
    logic        rspValid;
    logic        rspReady;
    logic [15:0] rspData;
    logic [3:0]  rspTag;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    rsp_t expQ[$];

    logic        stallSeen = 1'b0;
    logic [15:0] lastData;
    logic [3:0]  lastTag;

    always #5 clk = ~clk;

    assign aluResult = aluA + aluB;

    alu_issue_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .i_cmd_valid  (cmdValid),
        .o_cmd_ready  (cmdReady),
        .i_cmd_op     (cmdOp),
        .i_cmd_a      (cmdA),
        .i_cmd_b      (cmdB),
        .i_cmd_tag    (cmdTag),
        .i_cmd_chain  (cmdChain),
        .o_alu_a      (aluA),
        .o_alu_b      (aluB),
        .o_alu_op     (aluOp),
        .i_alu_result (aluResult),
        .o_rsp_valid  (rspValid),
        .i_rsp_ready  (rspReady),
        .o_rsp_data   (rspData),
        .o_rsp_tag    (rspTag),
        .o_busy       (busy)
    );

    // Single comparison point shared by stimulus and monitor.
    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Offer one command until accepted (bounded). Acceptance is decided at
    // the negedge since cmd_ready only moves on clock edges. Returns the
    // number of edges it took; on return we sit 1ns after the accepting edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic [3:0] tag,
                                 input logic chain, input logic [15:0] expData,
                                 output int edges);
        logic accepted = 1'b0;
        rsp_t entry;
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdA     = a;
        cmdB     = b;
        cmdTag   = tag;
        cmdChain = chain;
        edges    = 0;
        while (!accepted && edges < 50) begin
            @(negedge clk);
            if (cmdReady) begin
                entry.tag  = tag;
                entry.data = expData;
                expQ.push_back(entry);
                accepted   = 1'b1;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        cmdValid = 1'b0;
        cmdChain = 1'b0;
        if (!accepted) begin
            checkOutput("acceptTimeout", 32'd0, 32'd1);
        end
    endtask

    // Wait (bounded) for every queued expectation to be consumed.
    task automatic drain();
        int n = 0;
        while (expQ.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drainEmpty", 32'(expQ.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: compares handed-over responses against the scoreboard and
    // checks that a stalled response does not change.
    always @(negedge clk) begin
        rsp_t exp;
        if (rst) begin
            stallSeen = 1'b0;
        end else begin
            if (stallSeen) begin
                checkOutput("stallStable", {12'd0, rspTag, rspData},
                            {12'd0, lastTag, lastData});
            end
            stallSeen = rspValid && !rspReady;
            lastData  = rspData;
            lastTag   = rspTag;
            if (rspValid && rspReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedRsp", {12'd0, rspTag, rspData}, 32'hFFFF_FFFF);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("rspTag", 32'(rspTag), 32'(exp.tag));
                    checkOutput("rspData", 32'(rspData), 32'(exp.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int e;
        logic [15:0] bpA   [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
        logic [15:0] bpExp [4] = '{16'd101, 16'd102, 16'd103, 16'd104};
        logic [15:0] ppExp [4] = '{16'h0109, 16'h010A, 16'h010B, 16'h010C};

        rst = 1'b1;
        cmdValid = 1'b0; cmdOp = '0; cmdA = '0; cmdB = '0;
        cmdTag = '0; cmdChain = 1'b0; rspReady = 1'b0;
        #2;
        checkOutput("resetCmdReady", 32'(cmdReady), 32'd1);
        checkOutput("resetRspValid", 32'(rspValid), 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetAlu", {12'd0, aluOp, aluA}, 32'd0);
        checkOutput("resetAluB", 32'(aluB), 32'd0);
        checkOutput("resetRsp", {12'd0, rspTag, rspData}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single command, observe latency and busy with the consumer stalled.
        applyStimulus(4'hA, 16'd3, 16'd4, 4'd1, 1'b0, 16'd7, e);
        @(negedge clk);
        checkOutput("aluDrive", {aluOp, aluA, 12'd0}, {4'hA, 16'd3, 12'd0});
        checkOutput("aluB", 32'(aluB), 32'd4);
        checkOutput("validAfter1Edge", 32'(rspValid), 32'd0);
        checkOutput("busyInFlight", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("validAfter2Edges", 32'(rspValid), 32'd1);
        @(posedge clk);
        #1;
        rspReady = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("busyAfterPop", 32'(busy), 32'd0);
        checkOutput("validAfterPop", 32'(rspValid), 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back chain using the forwarded in-flight result.
        applyStimulus(4'h0, 16'd10, 16'd5, 4'd0, 1'b0, 16'd15, e);
        applyStimulus(4'h0, 16'hDEAD, 16'd1, 4'd1, 1'b1, 16'd16, e);
        checkOutput("noBubble", 32'(e), 32'd1);

        // Chain from idle using the accumulator, result wraps to zero.
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(4'h0, 16'h1234, 16'hFFF0, 4'd2, 1'b1, 16'h0000, e);
        drain();

        // Backpressure: four accepted, fifth waits for the first pop.
        rspReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'h1, bpA[i], 16'd100, 4'(3 + i), 1'b0, bpExp[i], e);
        end
        cmdValid = 1'b1; cmdA = 16'd50; cmdB = 16'd50; cmdTag = 4'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("readyLowFull", 32'(cmdReady), 32'd0);
        end
        @(posedge clk);
        #1;
        rspReady = 1'b1;
        applyStimulus(4'h1, 16'd50, 16'd50, 4'd7, 1'b0, 16'd100, e);
        checkOutput("fifthAfterPop", 32'(e), 32'd2);
        applyStimulus(4'h1, 16'd7, 16'd8, 4'd8, 1'b0, 16'd15, e);
        drain();

        // Push and pop on the same edge at count 3.
        rspReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'h2, 16'(9 + i), 16'h0100, 4'(9 + i), 1'b0, ppExp[i], e);
        end
        rspReady = 1'b1;
        @(posedge clk);
        #1;
        rspReady = 1'b0;
        @(negedge clk);
        checkOutput("countHeld", 32'(dut.w_fifoCount), 32'd3);
        checkOutput("readyAfterPushPop", 32'(cmdReady), 32'd1);
        @(posedge clk);
        #1;
        rspReady = 1'b1;
        drain();

        // Asynchronous reset with two queued results and one in flight.
        rspReady = 1'b0;
        applyStimulus(4'h3, 16'd1, 16'd1, 4'd13, 1'b0, 16'd2, e);
        applyStimulus(4'h3, 16'd2, 16'd2, 4'd14, 1'b0, 16'd4, e);
        applyStimulus(4'h3, 16'd3, 16'd3, 4'd15, 1'b0, 16'd6, e);
        #2;
        rst = 1'b1;
        #1;
        expQ.delete();
        checkOutput("rstRspValid", 32'(rspValid), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstAcc", 32'(dut.r_acc), 32'd0);
        checkOutput("rstCmdReady", 32'(cmdReady), 32'd1);
        checkOutput("rstRspData", 32'(rspData), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rspReady = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        applyStimulus(4'h0, 16'hBEEF, 16'd5, 4'd1, 1'b1, 16'd5, e);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential command front-end that sits in front of the combinational ALU datapath and drives its A/B/op inputs. It accepts operation commands over a valid/ready stream, registers them onto the ALU ports for exactly one cycle, captures the ALU result, and returns tagged results over a second valid/ready stream. A running accumulator lets a command take the previous result as its A operand.

## Interface
Parameters:
- WIDTH, 16, operand/result width
- OP_W, 4, op code width; opaque to this block
- TAG_W, 4, command tag width
- FIFO_DEPTH, 4, result FIFO entries; power of two, ≥2

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command slot available
- cmd_op  in  OP_W  operation code
- cmd_a  in  WIDTH  operand A; ignored when cmd_chain=1
- cmd_b  in  WIDTH  operand B
- cmd_tag  in  TAG_W  returned unchanged with the result
- cmd_chain  in  1  use accumulator as A
- alu_a, alu_b  out  WIDTH  to ALU A/B
- alu_op  out  OP_W  to ALU op
- alu_result  in  WIDTH  combinational ALU output
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_data  out  WIDTH  result
- rsp_tag  out  TAG_W  tag of that result
- busy  out  1  issue register or FIFO non-empty

## Operation
- Command accepted on a rising edge with cmd_valid && cmd_ready.
- Issue register (valid, op, a, b, tag) loads on acceptance. It clears on a non-accepting edge. alu_a/alu_b/alu_op are driven directly from it.
- A selection at acceptance:
  - cmd_chain=0: cmd_a.
  - cmd_chain=1 with the issue register valid: forward alu_result, i.e. the result of the in-flight command. No stall.
  - cmd_chain=1 with the issue register empty: accumulator.
- On the edge after acceptance, while the issue register is valid:
  - Push {tag, alu_result} into the result FIFO.
  - Accumulator <= alu_result.
- Accumulator: WIDTH bits, holds the last executed result, unchanged while idle.
- cmd_ready = (fifo_count + issue_valid) < FIFO_DEPTH.
  - Credit-based, so the FIFO can never overflow.
  - No combinational path from rsp_ready or cmd_valid.
- The FIFO presents its head on rsp_*. A pop occurs on an edge with rsp_valid && rsp_ready.
- Simultaneous push and pop is legal at any occupancy that permits the push. The count is then unchanged.
- Pointers wrap modulo FIFO_DEPTH. Results return in command order.
- Op codes are passed through unmodified. No decoding is done here.

## Timing
- Reset values:
  - cmd_ready=1, rsp_valid=0, busy=0.
  - alu_a=0, alu_b=0, alu_op=0.
  - rsp_data=0, rsp_tag=0, accumulator=0.
- Reset mid-operation discards the issue register and all FIFO contents. No response is produced for in-flight commands.
- Latency: acceptance at edge E0 → ALU ports valid in cycle E0..E1 → rsp_valid high after E1. That is 2 edges, at minimum, with the FIFO empty.
- Throughput is 1 command/cycle sustained while rsp_ready=1.
- With rsp_ready=0, exactly FIFO_DEPTH commands are accepted, then cmd_ready=0. The first rsp pop re-raises cmd_ready after that edge.
- rsp_data/rsp_tag are stable while rsp_valid && !rsp_ready.
- alu_* hold their last values when the issue register is empty. They are not zeroed.

## Structure
- Package alu_issue_pkg:
  - WIDTH/OP_W/TAG_W defaults.
  - typedef struct rsp_t {tag, data}.
  - typedef struct cmd_t {op, a, b, tag, chain}.
- Sub-module alu_rsp_fifo: parameterised synchronous FIFO of rsp_t with push, pop, count, empty, and async active-high reset.
- Top-level contains the issue register, A-select/forwarding mux, accumulator, and cmd_ready logic.

## Test plan
The bench models the ALU as alu_result = alu_a + alu_b (mod 2^16).
- Single command: a=3, b=4, tag=1, chain=0. Required: rsp_data=7, rsp_tag=1, rsp_valid high 2 edges after acceptance, busy drops one edge after the pop.
- Back-to-back chain with forwarding:
  - cmd0: a=10, b=5, tag=0.
  - cmd1, next cycle: chain=1, b=1, tag=1.
  - Required: results 15 then 16, no bubble on cmd_ready.
- Chain from idle: after the 16 result, idle 3 cycles, then chain=1, b=0xFFF0. Required: rsp_data=0x0000 (wrap).
- Backpressure:
  - Hold rsp_ready=0 and offer 6 commands.
  - Required: exactly 4 accepted, cmd_ready=0 thereafter.
  - Then raise rsp_ready. Required: results in tag order, and the 5th command is accepted the cycle after the first pop.
- Simultaneous push/pop at FIFO count 3: count stays 3, no data loss, order preserved.
- Reset asserted asynchronously with 2 results queued and 1 in flight. Required: rsp_valid=0 immediately, busy=0, accumulator=0, and no stale responses after deassertion.
